// File: rtl/sa_scan_pkg.sv
// Shared definitions for the scan register bank family: counter-width helper
// and the per-edge chain operating mode.
package sa_scan_pkg;

  typedef enum logic [1:0] {
    SCAN_HOLD    = 2'd0,
    SCAN_CAPTURE = 2'd1,
    SCAN_SHIFT   = 2'd2
  } scan_mode_e;

  // Width of a shift-cycle counter for an n-cycle frame, never below 1 bit.
  function automatic int calc_cw(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sa_scan_frame_cnt.sv
// Shift-frame counter: counts consecutive shift cycles modulo NSHIFT and
// emits a registered one-cycle pulse after each frame-completing shift.
module sa_scan_frame_cnt
  import sa_scan_pkg::*;
#(
  parameter int NSHIFT = 4,
  parameter int CW     = calc_cw(NSHIFT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shift_en,
  output logic [CW-1:0] cnt,
  output logic          done
);

  localparam logic [CW-1:0] LAST = CW'(NSHIFT - 1);

  logic last_shift;

  assign last_shift = shift_en && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= last_shift;
      // Any non-shift edge abandons a partial frame.
      if (!shift_en || last_shift) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sa_scan_reg_bank.sv
// Multi-bit, multi-lane scan register with capture, optional shadow output
// stage and a shift-frame counter.
module sa_scan_reg_bank
  import sa_scan_pkg::*;
#(
  parameter int              WIDTH     = 8,
  parameter int              LANES     = 1,
  parameter int              SHADOW    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int             NSHIFT    = WIDTH / LANES,
  localparam int             CW        = calc_cw(NSHIFT)
) (
  input  logic             CP,
  input  logic             RST,
  input  logic             SE,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  input  logic [LANES-1:0] SI,
  input  logic             UPD,
  output logic [WIDTH-1:0] Q,
  output logic [LANES-1:0] SO,
  output logic             SDONE,
  output logic [CW-1:0]    SCNT
);

  logic [WIDTH-1:0] chain;
  logic [WIDTH-1:0] shift_val;
  scan_mode_e       mode;

  // A full-width lane set replaces the whole chain in one shift.
  generate
    if (WIDTH == LANES) begin : g_full_shift
      assign shift_val = SI;
    end else begin : g_part_shift
      assign shift_val = {chain[WIDTH-LANES-1:0], SI};
    end
  endgenerate

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    mode = SCAN_HOLD;
    if (SE) begin
      mode = SCAN_SHIFT;
    end else if (EN) begin
      mode = SCAN_CAPTURE;
    end
  end

  always_ff @(posedge CP) begin
    if (RST) begin
      chain <= RESET_VAL;
    end else begin
      unique case (mode)
        SCAN_SHIFT:   chain <= shift_val;
        SCAN_CAPTURE: chain <= D;
        default:      chain <= chain;
      endcase
    end
  end

  assign SO = chain[WIDTH-1 -: LANES];

  generate
    if (SHADOW != 0) begin : g_shadow
      logic [WIDTH-1:0] shadow;

      // Shadow copies the pre-edge chain, so an update in a shift cycle
      // publishes the frame that just finished shifting in.
      always_ff @(posedge CP) begin
        if (RST) begin
          shadow <= RESET_VAL;
        end else if (UPD) begin
          shadow <= chain;
        end
      end

      assign Q = shadow;
    end else begin : g_no_shadow
      logic unused_upd;
      assign unused_upd = UPD;
      assign Q          = chain;
    end
  endgenerate

  sa_scan_frame_cnt #(
    .NSHIFT (NSHIFT),
    .CW     (CW)
  ) u_frame_cnt (
    .clk      (CP),
    .rst      (RST),
    .shift_en (SE),
    .cnt      (SCNT),
    .done     (SDONE)
  );

endmodule

// File: tb/tb_sa_scan_reg_bank.sv
// Self-checking bench for sa_scan_reg_bank: directed scenarios plus random
// traffic against an arithmetic reference model of the shadowed 8x2 bank.
module tb_sa_scan_reg_bank;

  logic       CP = 1'b0;
  logic       RST = 1'b1, SE = 1'b0, EN = 1'b0, UPD = 1'b0;
  logic [7:0] D = '0;
  logic [1:0] SI = '0;
  logic [7:0] Q;
  logic [1:0] SO;
  logic       SDONE;
  logic [1:0] SCNT;

  logic       b_rst = 1'b1, b_se = 1'b0, b_en = 1'b0, b_upd = 1'b0;
  logic [7:0] b_d = '0, b_si = '0;
  logic [7:0] b_q, b_so;
  logic       b_sdone;
  logic [0:0] b_scnt;

  int errors = 0;
  int checks = 0;

  // Reference model of the default instance (8 bits, 2 lanes, shadowed).
  int m_chain = 0, m_shadow = 0, m_pos = 0;
  int m_done = 0;

  always #5 CP = ~CP;

  sa_scan_reg_bank #(.WIDTH(8), .LANES(2), .SHADOW(1), .RESET_VAL(8'h00)) dut (
    .CP(CP), .RST(RST), .SE(SE), .EN(EN), .D(D), .SI(SI), .UPD(UPD),
    .Q(Q), .SO(SO), .SDONE(SDONE), .SCNT(SCNT)
  );

  sa_scan_reg_bank #(.WIDTH(8), .LANES(8), .SHADOW(0), .RESET_VAL(8'h00)) dut_b (
    .CP(CP), .RST(b_rst), .SE(b_se), .EN(b_en), .D(b_d), .SI(b_si), .UPD(b_upd),
    .Q(b_q), .SO(b_so), .SDONE(b_sdone), .SCNT(b_scnt)
  );

  // Drive one cycle on the default instance, advance the model, sample at +1.
  task automatic step(input logic rst, input logic se, input logic en,
                      input logic [7:0] d, input logic [1:0] si, input logic upd);
    RST = rst; SE = se; EN = en; D = d; SI = si; UPD = upd;
    @(posedge CP);
    #1;
    if (rst) begin
      m_chain = 0; m_shadow = 0; m_pos = 0; m_done = 0;
    end else begin
      if (upd) m_shadow = m_chain;
      if (se) begin
        m_done  = (m_pos == 3) ? 1 : 0;
        m_pos   = (m_pos + 1) % 4;
        m_chain = (m_chain * 4 + int'(si)) % 256;
      end else begin
        m_done = 0;
        m_pos  = 0;
        if (en) m_chain = int'(d);
      end
    end
    RST = 1'b0; SE = 1'b0; EN = 1'b0; UPD = 1'b0;
  endtask

  task automatic step_b(input logic rst, input logic se, input logic en,
                        input logic [7:0] d, input logic [7:0] si, input logic upd);
    b_rst = rst; b_se = se; b_en = en; b_d = d; b_si = si; b_upd = upd;
    @(posedge CP);
    #1;
    b_rst = 1'b0; b_se = 1'b0; b_en = 1'b0; b_upd = 1'b0;
  endtask

  task automatic test_reset;
    step(1'b1, 1'b0, 1'b0, 8'h5A, 2'b11, 1'b1);
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL reset_q got=%h exp=00", Q); end
    checks++; if (SCNT !== 2'd0) begin errors++; $display("FAIL reset_scnt got=%0d exp=0", SCNT); end
    checks++; if (SDONE !== 1'b0) begin errors++; $display("FAIL reset_sdone got=%b exp=0", SDONE); end
    checks++; if (SO !== 2'b00) begin errors++; $display("FAIL reset_so got=%b exp=00", SO); end
  endtask

  task automatic test_capture;
    step(1'b0, 1'b0, 1'b1, 8'hA5, 2'b00, 1'b0);
    checks++; if (SO !== 2'b10) begin errors++; $display("FAIL capture_so got=%b exp=10", SO); end
    checks++; if (Q !== 8'h00) begin errors++; $display("FAIL capture_q_stable got=%h exp=00", Q); end
  endtask

  task automatic test_shift_frame;
    logic [1:0] exp_so [4] = '{2'd2, 2'd1, 2'd1, 2'd3};
    logic       exp_dn [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'h00, 2'b11, 1'b0);
      checks++; if (SO !== exp_so[i]) begin errors++; $display("FAIL frame_so[%0d] got=%0d exp=%0d", i, SO, exp_so[i]); end
      checks++; if (SDONE !== exp_dn[i]) begin errors++; $display("FAIL frame_sdone[%0d] got=%b exp=%b", i, SDONE, exp_dn[i]); end
      checks++; if (Q !== 8'h00) begin errors++; $display("FAIL frame_q[%0d] got=%h exp=00", i, Q); end
    end
    step(1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1);
    checks++; if (Q !== 8'hFF) begin errors++; $display("FAIL frame_chain got=%h exp=ff", Q); end
    checks++; if (SDONE !== 1'b0) begin errors++; $display("FAIL frame_sdone_clear got=%b exp=0", SDONE); end
  endtask

  task automatic test_update_during_shift;
    step(1'b0, 1'b0, 1'b1, 8'hFF, 2'b00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b1);
    checks++; if (Q !== 8'hFF) begin errors++; $display("FAIL upd_shift_q got=%h exp=ff", Q); end
    checks++; if (SCNT !== 2'd1) begin errors++; $display("FAIL upd_shift_scnt got=%0d exp=1", SCNT); end
    step(1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1);
    checks++; if (Q !== 8'hFC) begin errors++; $display("FAIL upd_shift_chain got=%h exp=fc", Q); end
  endtask

  task automatic test_abandon;
    int pulses, first_at, gap;
    step(1'b0, 1'b1, 1'b0, 8'h00, 2'b01, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 2'b01, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    checks++; if (SCNT !== 2'd0) begin errors++; $display("FAIL abandon_scnt got=%0d exp=0", SCNT); end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00, 2'b10, 1'b0);
      if (SDONE === 1'b1) pulses++;
    end
    checks++; if (SDONE !== 1'b1 || pulses != 1) begin
      errors++; $display("FAIL abandon_one_pulse got=%0d(last=%b) exp=1(last=1)", pulses, SDONE);
    end
    step(1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
    pulses = 0; first_at = -1; gap = -1;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00, 2'(i), 1'b0);
      if (SDONE === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = i; else gap = i - first_at;
      end
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
    checks++; if (gap != 4) begin errors++; $display("FAIL b2b_gap got=%0d exp=4", gap); end
  endtask

  task automatic test_midframe_reset;
    int pulses;
    step(1'b0, 1'b0, 1'b1, 8'hC3, 2'b00, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 2'b01, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 2'b01, 1'b0);
    checks++; if (SCNT !== 2'd2) begin errors++; $display("FAIL midrst_pre_scnt got=%0d exp=2", SCNT); end
    step(1'b1, 1'b1, 1'b1, 8'hFF, 2'b11, 1'b1);
    checks++; if (SCNT !== 2'd0 || SDONE !== 1'b0) begin
      errors++; $display("FAIL midrst_cnt got=%0d/%b exp=0/0", SCNT, SDONE);
    end
    checks++; if (SO !== 2'b00 || Q !== 8'h00) begin
      errors++; $display("FAIL midrst_state got so=%b q=%h exp so=00 q=00", SO, Q);
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
      if (SDONE === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_no_pulse got=%0d exp=0", pulses); end
  endtask

  task automatic test_random;
    logic r, s, e, u;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 2) != 0);
      e = $urandom_range(0, 1);
      u = ($urandom_range(0, 3) == 0);
      step(r, s, e, 8'($urandom), 2'($urandom), u);
      checks++; if (Q !== 8'(m_shadow)) begin errors++; $display("FAIL rand_q[%0d] got=%h exp=%h", i, Q, 8'(m_shadow)); end
      checks++; if (SO !== 2'(m_chain / 64)) begin errors++; $display("FAIL rand_so[%0d] got=%0d exp=%0d", i, SO, m_chain / 64); end
      checks++; if (SCNT !== 2'(m_pos)) begin errors++; $display("FAIL rand_scnt[%0d] got=%0d exp=%0d", i, SCNT, m_pos); end
      checks++; if (SDONE !== 1'(m_done)) begin errors++; $display("FAIL rand_sdone[%0d] got=%b exp=%0d", i, SDONE, m_done); end
    end
  endtask

  task automatic test_no_shadow;
    step_b(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    checks++; if (b_q !== 8'h00 || b_scnt !== 1'b0 || b_sdone !== 1'b0) begin
      errors++; $display("FAIL ns_reset got q=%h scnt=%0d sdone=%b exp 00/0/0", b_q, b_scnt, b_sdone);
    end
    step_b(1'b0, 1'b0, 1'b1, 8'h3C, 8'h00, 1'b0);
    checks++; if (b_q !== 8'h3C) begin errors++; $display("FAIL ns_capture got=%h exp=3c", b_q); end
    step_b(1'b0, 1'b1, 1'b1, 8'h11, 8'hC3, 1'b0);
    checks++; if (b_q !== 8'hC3 || b_so !== 8'hC3) begin
      errors++; $display("FAIL ns_shift got q=%h so=%h exp=c3", b_q, b_so);
    end
    checks++; if (b_sdone !== 1'b1 || b_scnt !== 1'b0) begin
      errors++; $display("FAIL ns_sdone got=%b scnt=%0d exp=1/0", b_sdone, b_scnt);
    end
    for (int i = 0; i < 3; i++) begin
      step_b(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'(i % 2 == 0));
      checks++; if (b_q !== 8'hC3 || b_sdone !== 1'b0) begin
        errors++; $display("FAIL ns_upd_ignored[%0d] got q=%h sdone=%b exp c3/0", i, b_q, b_sdone);
      end
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_shift_frame();
    test_update_during_shift();
    test_abandon();
    test_midframe_reset();
    test_random();
    test_no_shadow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
